// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline-stage register family.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Bubble payloads are replicated from these bits to the chosen width.
  localparam logic BUBBLE_PC_BIT   = 1'b0;
  localparam logic BUBBLE_INST_BIT = 1'b1;

  localparam logic RstEnable = 1'b1;

endpackage

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with a one-entry skid slot, flush, bubble payloads
// and a saturating back-pressure counter; in_ready is a flop, not a comb path.
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_W_DEF,
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] BUBBLE_PC   = {ADDR_W{BUBBLE_PC_BIT}},
  parameter logic [DATA_W-1:0] BUBBLE_INST = {DATA_W{BUBBLE_INST_BIT}},
  parameter int unsigned       CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_n;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_n, main_pc_n;
  logic [DATA_W-1:0] skid_inst_q, skid_inst_n, main_inst_n;
  logic [CNT_W-1:0]  stall_n;
  logic              accept, drain;

  // Next state, slot contents and counter; flush overrides every handshake.
  always_comb begin
    state_n     = state_q;
    main_pc_n   = out_pc;
    main_inst_n = out_inst;
    skid_pc_n   = skid_pc_q;
    skid_inst_n = skid_inst_q;
    stall_n     = stall_cnt;
    accept      = in_valid & in_ready;
    drain       = out_valid & out_ready;

    if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_n = stall_cnt + CNT_W'(1);
    end

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_n     = ONE;
          main_pc_n   = in_pc;
          main_inst_n = in_inst;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_pc_n   = in_pc;
          main_inst_n = in_inst;
        end else if (accept) begin
          state_n     = TWO;
          skid_pc_n   = in_pc;
          skid_inst_n = in_inst;
        end else if (drain) begin
          state_n     = EMPTY;
          main_pc_n   = BUBBLE_PC;
          main_inst_n = BUBBLE_INST;
        end
      end
      TWO: begin
        if (drain) begin
          state_n     = ONE;
          main_pc_n   = skid_pc_q;
          main_inst_n = skid_inst_q;
          skid_pc_n   = BUBBLE_PC;
          skid_inst_n = BUBBLE_INST;
        end
      end
      default: begin
        state_n     = EMPTY;
        main_pc_n   = BUBBLE_PC;
        main_inst_n = BUBBLE_INST;
        skid_pc_n   = BUBBLE_PC;
        skid_inst_n = BUBBLE_INST;
      end
    endcase

    if (flush) begin
      state_n     = EMPTY;
      main_pc_n   = BUBBLE_PC;
      main_inst_n = BUBBLE_INST;
      skid_pc_n   = BUBBLE_PC;
      skid_inst_n = BUBBLE_INST;
    end
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      out_pc      <= BUBBLE_PC;
      out_inst    <= BUBBLE_INST;
      skid_pc_q   <= BUBBLE_PC;
      skid_inst_q <= BUBBLE_INST;
      stall_cnt   <= '0;
    end else begin
      state_q     <= state_n;
      out_valid   <= (state_n != EMPTY);
      in_ready    <= (state_n != TWO);
      out_pc      <= main_pc_n;
      out_inst    <= main_inst_n;
      skid_pc_q   <= skid_pc_n;
      skid_inst_q <= skid_inst_n;
      stall_cnt   <= stall_n;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: scoreboard of accepted entries checked on drain,
// plus a second instance with a 2-bit counter for saturation.
module tb_pipe_reg_skid;
  import pipe_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] in_pc = '0;
  logic [DW-1:0] in_inst = '0;

  logic          in_ready, out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic [15:0]   stall_cnt;

  logic          s_in_ready, s_out_valid;
  logic [AW-1:0] s_out_pc;
  logic [DW-1:0] s_out_inst;
  logic [1:0]    s_stall_cnt;

  ent_t        sb[$];
  int          passed = 0;
  int          total = 0;
  int          fails = 0;
  logic [15:0] exp_stall = '0;
  logic [1:0]  exp_stall_s = '0;
  bit          last_accept = 1'b0;
  bit          done;

  always #5 clk = ~clk;

  pipe_reg_skid u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .stall_cnt(stall_cnt)
  );

  pipe_reg_skid #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_inst(s_out_inst),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the handshakes seen at the coming edge, then move past it.
  task automatic step();
    ent_t e;
    @(negedge clk);
    last_accept = 1'b0;
    if (!rst) begin
      if (out_valid && !out_ready) begin
        if (exp_stall != '1)   exp_stall++;
        if (exp_stall_s != '1) exp_stall_s++;
      end
      if (flush) begin
        last_accept = in_valid && in_ready;
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("drain_pc", 64'(out_pc), 64'(e.pc));
            chk("drain_inst", 64'(out_inst), 64'(e.inst));
          end
        end
        if (!out_valid) begin
          chk("bubble_pc", 64'(out_pc), 64'h0);
          chk("bubble_inst", 64'(out_inst), 64'hFFFF_FFFF);
        end
        if (in_valid && in_ready) begin
          e.pc   = in_pc;
          e.inst = in_inst;
          sb.push_back(e);
          last_accept = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] pc, input logic [DW-1:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect immediately.
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'hFFFF_FFFF);
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_stall_small", 64'(s_stall_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming at full throughput.
    out_ready = 1'b1;
    offer(32'h00, 32'hA); step();
    chk("stream_lat_valid", 64'(out_valid), 64'd1);
    chk("stream_lat_pc", 64'(out_pc), 64'h00);
    offer(32'h04, 32'hB); step();
    chk("stream_ready1", 64'(in_ready), 64'd1);
    chk("stream_pc1", 64'(out_pc), 64'h04);
    offer(32'h08, 32'hC); step();
    chk("stream_ready2", 64'(in_ready), 64'd1);
    chk("stream_inst2", 64'(out_inst), 64'hC);
    in_valid = 1'b0;
    step(); step();
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure fills the skid slot; a third offer waits.
    out_ready = 1'b0;
    offer(32'h10, 32'h10); step();
    offer(32'h14, 32'h14); step();
    chk("bp_in_ready_two", 64'(in_ready), 64'd0);
    chk("bp_head_pc", 64'(out_pc), 64'h10);
    offer(32'h18, 32'h18); step(); step();
    chk("bp_held_ready", 64'(in_ready), 64'd0);
    chk("bp_held_head", 64'(out_pc), 64'h10);
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      step();
      if (last_accept) done = 1'b1;
    end
    chk("bp_accept_bound", 64'(done), 64'd1);
    in_valid = 1'b0;
    step(); step(); step();
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    chk("bp_stall", 64'(stall_cnt), 64'(exp_stall));

    // Stall counter counts and the 2-bit copy saturates.
    rst = 1'b1;
    sb.delete();
    exp_stall = '0;
    exp_stall_s = '0;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    offer(32'h20, 32'h20); step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("stall_5", 64'(stall_cnt), 64'd5);
    chk("stall_small_5", 64'(s_stall_cnt), 64'd3);
    step();
    chk("stall_6", 64'(stall_cnt), 64'd6);
    chk("stall_small_sat", 64'(s_stall_cnt), 64'd3);

    // Flush while TWO with a simultaneous drain and an offer pending.
    offer(32'h24, 32'h24); step();
    chk("fl_two_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    offer(32'h28, 32'h28); step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_inst", 64'(out_inst), 64'hFFFF_FFFF);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_stall_kept", 64'(stall_cnt), 64'(exp_stall));
    step(); step();
    chk("fl_stays_empty", 64'(out_valid), 64'd0);

    // Flush while ONE with accept and drain both completing.
    offer(32'h30, 32'h30); step();
    flush = 1'b1;
    offer(32'h34, 32'h34); step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl1_dropped", 64'(out_valid), 64'd0);

    // A stalled cycle coinciding with flush still counts.
    out_ready = 1'b0;
    offer(32'h40, 32'h40); step();
    in_valid = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0;
    chk("fl_stall_counts", 64'(stall_cnt), 64'(exp_stall));
    chk("fl_stall_small", 64'(s_stall_cnt), 64'(exp_stall_s));

    // Reset mid-stream from TWO.
    offer(32'h50, 32'h50); step();
    offer(32'h54, 32'h54); step();
    in_valid = 1'b0;
    chk("mr_two", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    chk("mr_out_pc", 64'(out_pc), 64'h0);
    chk("mr_stall", 64'(stall_cnt), 64'd0);
    sb.delete();
    exp_stall = '0;
    exp_stall_s = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    offer(32'h60, 32'h6); step();
    in_valid = 1'b0;
    chk("mr_lat_valid", 64'(out_valid), 64'd1);
    chk("mr_lat_pc", 64'(out_pc), 64'h60);
    step(); step();
    chk("mr_sb_empty", 64'(sb.size()), 64'd0);
    chk("small_tracks_valid", 64'(s_out_valid), 64'(out_valid));
    chk("small_tracks_data", 64'({s_in_ready, s_out_pc, s_out_inst}),
        64'({in_ready, out_pc, out_inst}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
